mat_data_mem_mp: RTL and testbench
==================================

Name: mat_data_mem_mp

Overview:
- Multi-port successor to the single-port matrix data memory.
- Holds DATA_MEM_SIZE rows of WIDTH elements and serves NUM_PORTS independent requesters, e.g. the matrix controller plus a host/DMA loader.
- Each port uses a valid/ready request handshake and gets a registered response.
- A round-robin arbiter grants one access per cycle. Row reads, full-row writes and single-element writes are supported, with out-of-range detection.

Parameters:
- WIDTH, 16, elements per row
- ELEM_BITS, 32, bits per element (IEEE single, opaque to this block)
- DATA_MEM_SIZE, 1024, number of rows
- DATA_MEM_ADDR_SIZE, 32, row address width
- NUM_PORTS, 2, requester count (1..8)
- WIDTH_ADDR_SIZE, $clog2(WIDTH), element index width (derived)

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  [NUM_PORTS]  request present
- req_ready  out  [NUM_PORTS]  request accepted this cycle
- req_op  in  [NUM_PORTS] x MatMemOp_t  READ / WRITE_ROW / WRITE_ELEM
- req_addr  in  [NUM_PORTS] x DATA_MEM_ADDR_SIZE  row address
- req_elem  in  [NUM_PORTS] x WIDTH_ADDR_SIZE  element index (WRITE_ELEM only)
- req_data  in  [NUM_PORTS] x WIDTH x ELEM_BITS  write row; for WRITE_ELEM only element 0 is used
- rsp_valid  out  [NUM_PORTS]  one-cycle response pulse
- rsp_error  out  [NUM_PORTS]  address out of range
- rsp_data  out  [NUM_PORTS] x WIDTH x ELEM_BITS  read row
- conflict_count  out  32  cycles in which ≥2 ports were valid

Behaviour:
- Reset:
  - rr pointer = 0; all rsp_valid, rsp_error and rsp_data = 0; conflict_count = 0.
  - Memory contents are not cleared.
  - While reset is high, req_ready = 0 and no writes occur.
  - A response pending when reset asserts is dropped.
- Arbitration:
  - req_ready[p] is combinational and is 1 only for the granted port, at most one port per cycle.
  - Grant goes to the first valid port scanning from the rr pointer upward, with wrap-around.
  - After a grant to port p, the pointer becomes (p+1) mod NUM_PORTS.
  - With no valid requests, the pointer holds.
  - A port with valid and no ready must hold all req_* stable.
- Accept = valid & ready. Exactly one access is performed on the accept edge.
  - READ: the row is registered into rsp_data[p].
  - WRITE_ROW: all WIDTH elements are written.
  - WRITE_ELEM: only element req_elem is written; the others are unchanged.
- Latency: rsp_valid[p] pulses in the cycle after accept, for every op (writes are acknowledged).
  - rsp_data holds its last value until the next READ response for that port.
  - Back-to-back accepts on the same port give back-to-back responses.
- Ordering: a write accepted in cycle N is visible to any read accepted in cycle N+1 or later, from any port. Same-cycle conflicts are impossible because of the single grant.
- Range check: req_addr ≥ DATA_MEM_SIZE is still accepted, but:
  - memory is not modified;
  - the response carries rsp_error = 1 and rsp_data = 0.
- conflict_count increments on each cycle with ≥2 req_valid while not in reset, and saturates at 2^32-1.
- NUM_PORTS = 1 degenerates to ready = valid with no arbitration state.

Decomposition:
- Package mat_pkg:
  - MatMemOp_t enum (2 bits): READ=0, WRITE_ROW=1, WRITE_ELEM=2, 3 reserved and treated as READ.
  - Element type alias of ELEM_BITS.
- Sub-module mat_rr_arbiter (NUM_PORTS): request vector in, one-hot grant out, pointer update on accept. Reusable for the cache ports.

Test Plan:
- Single port, WRITE_ROW at addr 5 with elements 0..15 = 1.0..16.0, then READ at addr 5 -> rsp_valid one cycle after each accept; read rsp_data = 1.0..16.0, rsp_error = 0.
- WRITE_ELEM at addr 5, elem 3, data 99.0, then READ at addr 5 -> element 3 = 99.0, all other elements unchanged.
- Ports 0 and 1 both issuing READs continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; each port gets 3 responses; conflict_count = 6.
- Port 0 WRITE_ROW at addr 7 (all 2.0) accepted at cycle N; port 1 READ at addr 7 accepted at N+1 -> port 1 receives all 2.0.
- READ at addr 1024 and WRITE_ROW at addr 2000 -> each accepted, rsp_error = 1, rsp_data = 0, memory checksum unchanged.
- Reset asserted in the cycle after an accept -> no rsp_valid, pointer back to 0, conflict_count = 0; a row written before reset still reads back intact.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types for the matrix data memory family.
//   MatMemOp_t   : 2-bit request opcode (READ / WRITE_ROW / WRITE_ELEM, code 3
//                  is reserved and behaves as READ)
//   mat_elem_t   : one matrix element (IEEE single, opaque here)
//   op_is_read() : true for READ and for the reserved code
package mat_pkg;

  localparam int MAT_ELEM_BITS = 32;

  typedef logic [MAT_ELEM_BITS-1:0] mat_elem_t;

  typedef enum logic [1:0] {
    READ       = 2'd0,
    WRITE_ROW  = 2'd1,
    WRITE_ELEM = 2'd2,
    OP_RSVD    = 2'd3
  } MatMemOp_t;

  // The reserved opcode is folded into READ so it never corrupts memory.
  function automatic logic op_is_read(input MatMemOp_t op);
    return !((op == WRITE_ROW) || (op == WRITE_ELEM));
  endfunction

endpackage

// File: rtl/mat_rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
//   clock, reset : synchronous active-high reset, pointer returns to 0
//   req          : request vector (caller masks it during reset)
//   grant        : one-hot grant, combinational from req and the pointer
// Every grant is an accept (the caller uses grant as ready), so the pointer
// advances to the port after the winner whenever any grant is issued and
// holds when nothing is requested.
module mat_rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

  if (NUM_PORTS == 1) begin : g_single
    assign grant = req;
  end else begin : g_rr
    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      ptr_next = ptr;
      // Scan upward from the pointer with wrap-around; first hit wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = (int'(ptr) + i) % NUM_PORTS;
        if ((grant == '0) && req[idx]) begin
          grant[idx] = 1'b1;
          ptr_next   = PTR_W'((idx + 1) % NUM_PORTS);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) ptr <= '0;
      else       ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/mat_data_mem_mp.sv
// Multi-port matrix data memory: DATA_MEM_SIZE rows of WIDTH elements shared
// by NUM_PORTS requesters through a round-robin arbiter.
//   clock, reset    : single clock, synchronous active-high reset
//   req_valid/ready : per-port handshake; accept = valid & ready. ready is
//                     combinational, high only for the granted port. A port
//                     holding valid without ready keeps all req_* stable.
//   req_op          : MatMemOp_t per port
//   req_addr        : row address; addresses >= DATA_MEM_SIZE are accepted but
//                     flagged and never touch memory
//   req_elem        : element index for WRITE_ELEM
//   req_data        : write row (WRITE_ELEM uses element 0 only)
//   rsp_valid       : one-cycle pulse the cycle after each accept
//   rsp_error       : out-of-range flag for that response
//   rsp_data        : read row; holds until the next READ or error response
//   conflict_count  : saturating count of cycles with two or more valid ports
module mat_data_mem_mp
  import mat_pkg::*;
#(
  parameter int WIDTH              = 16,
  parameter int ELEM_BITS          = MAT_ELEM_BITS,
  parameter int DATA_MEM_SIZE      = 1024,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int NUM_PORTS          = 2,
  parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUM_PORTS-1:0]                             req_valid,
  output logic [NUM_PORTS-1:0]                             req_ready,
  input  logic [NUM_PORTS-1:0][1:0]                        req_op,
  input  logic [NUM_PORTS-1:0][DATA_MEM_ADDR_SIZE-1:0]     req_addr,
  input  logic [NUM_PORTS-1:0][WIDTH_ADDR_SIZE-1:0]        req_elem,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0][ELEM_BITS-1:0]   req_data,
  output logic [NUM_PORTS-1:0]                             rsp_valid,
  output logic [NUM_PORTS-1:0]                             rsp_error,
  output logic [NUM_PORTS-1:0][WIDTH-1:0][ELEM_BITS-1:0]   rsp_data,
  output logic [31:0]                                      conflict_count
);

  localparam int ROW_IDX_W = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1;
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [WIDTH-1:0][ELEM_BITS-1:0] mem [DATA_MEM_SIZE];

  logic [NUM_PORTS-1:0] arb_req;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [NUM_PORTS-1:0] rsp_error_q;

  logic                            accept;
  logic [PORT_W-1:0]               sel_port;
  MatMemOp_t                       sel_op;
  logic [DATA_MEM_ADDR_SIZE-1:0]   sel_addr;
  logic [WIDTH_ADDR_SIZE-1:0]      sel_elem;
  logic [WIDTH-1:0][ELEM_BITS-1:0] sel_data;
  logic                            in_range;
  logic [ROW_IDX_W-1:0]            row_idx;

  // No grants (hence no accepts or writes) while reset is high.
  assign arb_req = reset ? '0 : req_valid;

  mat_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .grant (grant)
  );

  assign req_ready = grant;

  // Mux the single granted request onto the memory access path.
  always_comb begin
    accept   = 1'b0;
    sel_port = '0;
    sel_op   = READ;
    sel_addr = '0;
    sel_elem = '0;
    sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        accept   = 1'b1;
        sel_port = PORT_W'(p);
        sel_op   = MatMemOp_t'(req_op[p]);
        sel_addr = req_addr[p];
        sel_elem = req_elem[p];
        sel_data = req_data[p];
      end
    end
  end

  assign in_range = (sel_addr < DATA_MEM_ADDR_SIZE'(DATA_MEM_SIZE));
  assign row_idx  = sel_addr[ROW_IDX_W-1:0];

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (accept && in_range) begin
      if (sel_op == WRITE_ROW)       mem[row_idx]           <= sel_data;
      else if (sel_op == WRITE_ELEM) mem[row_idx][sel_elem] <= sel_data[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q    <= '0;
      rsp_error_q    <= '0;
      rsp_data       <= '0;
      conflict_count <= '0;
    end else begin
      rsp_valid_q <= grant;
      rsp_error_q <= '0;
      if (accept) begin
        rsp_error_q[sel_port] <= ~in_range;
        // An out-of-range response always carries a zero row, writes included.
        if (!in_range)              rsp_data[sel_port] <= '0;
        else if (op_is_read(sel_op)) rsp_data[sel_port] <= mem[row_idx];
      end
      if (($countones(req_valid) > 1) && (conflict_count != '1))
        conflict_count <= conflict_count + 32'd1;
    end
  end

  // A response still registered when reset rises is suppressed immediately.
  assign rsp_valid = rsp_valid_q & ~{NUM_PORTS{reset}};
  assign rsp_error = rsp_error_q & ~{NUM_PORTS{reset}};

endmodule

// File: tb/tb_mat_data_mem_mp.sv
module tb_mat_data_mem_mp;

  localparam int NP    = 2;
  localparam int W     = 16;
  localparam int EB    = 32;
  localparam int MS    = 1024;
  localparam int AW    = 32;
  localparam int EW    = 4;
  localparam int ROW_W = W * EB;
  localparam int EXP_W = 32 + 1 + ROW_W;  // {due cycle, error, row}

  typedef logic [W-1:0][EB-1:0] row_t;
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [EW-1:0] elem;
    row_t          data;
  } cmd_t;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [NP-1:0]               req_valid;
  logic [NP-1:0]               req_ready;
  logic [NP-1:0][1:0]          req_op;
  logic [NP-1:0][AW-1:0]       req_addr;
  logic [NP-1:0][EW-1:0]       req_elem;
  logic [NP-1:0][W-1:0][EB-1:0] req_data;
  logic [NP-1:0]               rsp_valid;
  logic [NP-1:0]               rsp_error;
  logic [NP-1:0][W-1:0][EB-1:0] rsp_data;
  logic [31:0]                 conflict_count;

  mat_data_mem_mp #(
    .WIDTH(W), .ELEM_BITS(EB), .DATA_MEM_SIZE(MS),
    .DATA_MEM_ADDR_SIZE(AW), .NUM_PORTS(NP)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_elem(req_elem), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .conflict_count(conflict_count)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  cmd_t               cmd_q [NP][$];
  logic [EXP_W-1:0]   exp_q [NP][$];
  bit   [NP-1:0]      busy;
  bit   [NP-1:0]      acc_flag;

  // reference model state
  row_t        model_mem [int unsigned];
  row_t        last_data [NP];
  int          exp_ptr;
  int          conf_model;

  int row_set [8] = '{0, 1, 3, 5, 7, 500, 976, 1023};
  int oor_set [4] = '{1024, 2000, 1029, -1};

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [EB-1:0] f32_of_int(input int n);
    int msb;
    logic [31:0] m;
    msb = 0;
    for (int b = 0; b < 23; b++) if (n[b]) msb = b;
    m = 32'(n) << (23 - msb);
    return {1'b0, 8'(msb + 127), m[22:0]};
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int e = 0; e < W; e++) r[e] = $urandom;
    return r;
  endfunction

  task automatic push_cmd(input int p, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [EW-1:0] elem, input row_t data);
    cmd_t c;
    c.op = op; c.addr = addr; c.elem = elem; c.data = data;
    cmd_q[p].push_back(c);
  endtask

  function automatic bit all_idle();
    for (int p = 0; p < NP; p++)
      if (cmd_q[p].size() != 0 || busy[p] || exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!all_idle() && n < 2000) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL timeout_%s act=busy exp=idle", tag);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    req_valid = '0; req_op = '0; req_addr = '0; req_elem = '0; req_data = '0;
    busy = '0;
    forever begin
      @(posedge clock); #1;
      for (int p = 0; p < NP; p++) begin
        cmd_t c;
        if (busy[p] && acc_flag[p]) busy[p] = 1'b0;
        if (!busy[p] && cmd_q[p].size() > 0) begin
          c = cmd_q[p].pop_front();
          req_op[p] = c.op; req_addr[p] = c.addr; req_elem[p] = c.elem; req_data[p] = c.data;
          busy[p] = 1'b1;
        end
        req_valid[p] = busy[p];
      end
    end
  end

  // ---------------- accept tracker + reference model ----------------
  task automatic model_accept(input int p);
    logic        oor;
    int unsigned a;
    row_t        r;
    a   = req_addr[p];
    oor = (a >= MS);
    case (req_op[p])
      2'd1: if (oor) last_data[p] = '0; else model_mem[a] = req_data[p];
      2'd2: if (oor) last_data[p] = '0;
            else begin
              r = model_mem[a];
              r[req_elem[p]] = req_data[p][0];
              model_mem[a] = r;
            end
      default: last_data[p] = oor ? '0 : model_mem[a];
    endcase
    exp_q[p].push_back({32'(cyc + 1), oor, last_data[p]});
  endtask

  initial begin
    acc_flag = '0;
    exp_ptr = 0;
    conf_model = 0;
    forever begin
      logic [NP-1:0] exp_grant;
      int gp;
      @(negedge clock);
      acc_flag = '0;
      if (reset) begin
        check("ready_in_reset", EXP_W'(req_ready), '0);
        check("rsp_valid_in_reset", EXP_W'(rsp_valid), '0);
        exp_ptr = 0;
        conf_model = 0;
        for (int p = 0; p < NP; p++) begin
          exp_q[p].delete();
          last_data[p] = '0;
        end
      end else begin
        check("conflict_count", EXP_W'(conflict_count), EXP_W'(conf_model));
        gp = -1;
        for (int i = 0; i < NP; i++)
          if (gp < 0 && req_valid[(exp_ptr + i) % NP]) gp = (exp_ptr + i) % NP;
        exp_grant = '0;
        if (gp >= 0) exp_grant[gp] = 1'b1;
        check("req_ready", EXP_W'(req_ready), EXP_W'(exp_grant));
        if (gp >= 0) begin
          model_accept(gp);
          acc_flag[gp] = 1'b1;
          exp_ptr = (gp + 1) % NP;
        end
        if ($countones(req_valid) >= 2) conf_model++;
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial forever begin
    logic [EXP_W-1:0] e;
    @(negedge clock);
    for (int p = 0; p < NP; p++) begin
      while (exp_q[p].size() > 0 && int'(exp_q[p][0][EXP_W-1 -: 32]) < cyc) begin
        e = exp_q[p].pop_front();
        checks++; errors++;
        $display("FAIL missing_rsp_p%0d act=none exp_due=%0d", p, e[EXP_W-1 -: 32]);
      end
      if (rsp_valid[p]) begin
        if (exp_q[p].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp_p%0d act=valid exp=none cyc=%0d", p, cyc);
        end else begin
          e = exp_q[p].pop_front();
          check($sformatf("rsp_p%0d", p), {32'(cyc), rsp_error[p], rsp_data[p]}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    row_t r;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rsp_data", EXP_W'(rsp_data), '0);
    check("reset_rsp_error", EXP_W'(rsp_error), '0);
    check("reset_conflict", EXP_W'(conflict_count), '0);
    @(posedge clock); #1 reset = 1'b0;

    // populate every row the bench will read
    for (int i = 0; i < 8; i++) push_cmd(i % NP, 2'd1, row_set[i], '0, rand_row());
    wait_idle("init");

    // row write 1.0..16.0 then read back
    for (int e = 0; e < W; e++) r[e] = f32_of_int(e + 1);
    push_cmd(0, 2'd1, 5, '0, r);
    push_cmd(0, 2'd0, 5, '0, '0);
    wait_idle("row_rw");

    // element write 99.0 into elem 3
    r = '0; r[0] = f32_of_int(99);
    push_cmd(0, 2'd2, 5, 4'd3, r);
    push_cmd(0, 2'd0, 5, '0, '0);
    wait_idle("elem_w");

    // both ports streaming reads straight out of reset
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 2'd0, row_set[i], '0, '0);
      push_cmd(1, 2'd0, row_set[i + 4], '0, '0);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_idle("stream");
    check("stream_conflicts", EXP_W'(conflict_count), EXP_W'(7));

    // write on port 0 then read on port 1 the following cycle
    for (int e = 0; e < W; e++) r[e] = 32'h4000_0000;
    @(negedge clock);
    push_cmd(0, 2'd1, 7, '0, r);
    @(posedge clock); #2;
    push_cmd(1, 2'd0, 7, '0, '0);
    wait_idle("w_then_r");

    // out-of-range accesses, then re-read every row
    push_cmd(0, 2'd0, 1024, '0, '0);
    push_cmd(1, 2'd1, 2000, '0, rand_row());
    push_cmd(0, 2'd2, 32'hFFFF_FFFF, 4'd7, rand_row());
    push_cmd(1, 2'd1, 1024, '0, rand_row());
    wait_idle("oor");
    for (int i = 0; i < 8; i++) push_cmd(i % NP, 2'd0, row_set[i], '0, '0);
    wait_idle("checksum");

    // reset in the cycle after an accept drops the response, keeps the write
    r = rand_row();
    push_cmd(0, 2'd1, 3, '0, r);
    begin
      int n;
      n = 0;
      while (!acc_flag[0] && n < 50) begin
        @(negedge clock); #1;
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL timeout_accept act=no_accept exp=accept");
      end
    end
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    push_cmd(1, 2'd0, 3, '0, '0);
    push_cmd(0, 2'd0, 3, '0, '0);
    wait_idle("post_reset");

    // randomized mixed traffic
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      for (int p = 0; p < NP; p++) begin
        if (cmd_q[p].size() < 2 && $urandom_range(0, 3) != 0) begin
          logic [AW-1:0] a;
          if ($urandom_range(0, 9) == 0) a = oor_set[$urandom_range(0, 3)];
          else                           a = row_set[$urandom_range(0, 7)];
          push_cmd(p, 2'($urandom_range(0, 3)), a, 4'($urandom_range(0, W - 1)), rand_row());
        end
      end
    end
    wait_idle("random");

    for (int p = 0; p < NP; p++)
      check($sformatf("drain_p%0d", p), EXP_W'(exp_q[p].size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
